// File: rtl/wb_ddr2_wbuf.sv
// Wishbone write-posting buffer in front of one DDR2 arbiter master port.
// Optional drain bursting within a 32-byte line: define DDR2_WBUF_DRAIN_BURST_EN.
module wb_ddr2_wbuf #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DEPTH_LOG = 3
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic [31:0]          s_adr_i,
    input  logic [31:0]          s_dat_i,
    input  logic [3:0]           s_sel_i,
    input  logic                 s_we_i,
    input  logic                 s_cyc_i,
    input  logic                 s_stb_i,
    input  logic [2:0]           s_cti_i,
    input  logic [1:0]           s_bte_i,
    output logic [31:0]          s_dat_o,
    output logic                 s_ack_o,
    output logic                 s_err_o,
    output logic                 s_rty_o,
    output logic [31:0]          m_adr_o,
    output logic [31:0]          m_dat_o,
    output logic [3:0]           m_sel_o,
    output logic                 m_we_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic [2:0]           m_cti_o,
    output logic [1:0]           m_bte_o,
    input  logic [31:0]          m_dat_i,
    input  logic                 m_ack_i,
    output logic [DEPTH_LOG:0]   wbuf_level,
    output logic                 wbuf_full
);

    localparam logic [DEPTH_LOG:0] FullLevel = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWr, StGap, StRd} state_e;

    state_e state_q, state_d;

    // Entry layout: {word address, byte selects, data}
    logic [65:0]          fifo_mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG:0]   level_q, level_d;

    logic [29:0] head_adr;
    logic [3:0]  head_sel;
    logic [31:0] head_dat;

    logic [29:0] rd_adr_q;
    logic [3:0]  rd_sel_q;
    logic [31:0] s_dat_q;
    logic        s_ack_q, s_ack_d;

    logic push, pop, burst_cont, rd_done, rd_ack;

    logic unused_inputs;
    assign unused_inputs = ^{s_bte_i, s_adr_i[1:0]};

    assign wbuf_full  = (level_q == FullLevel);
    assign wbuf_level = level_q;

    assign {head_adr, head_sel, head_dat} = fifo_mem[rd_ptr_q];

    // A pop in the same cycle frees the slot the held write needs.
    assign pop  = (state_q == StWr) & m_ack_i;
    assign push = s_cyc_i & s_stb_i & s_we_i & (!wbuf_full | pop) &
                  (!s_ack_o | (s_cti_i == 3'b010));

    assign rd_done = (state_q == StRd) & m_ack_i;
    assign rd_ack  = rd_done & s_cyc_i & s_stb_i & !s_we_i;

`ifdef DDR2_WBUF_DRAIN_BURST_EN
    logic [DEPTH_LOG-1:0] next_ptr;
    logic [29:0]          next_adr;

    assign next_ptr   = rd_ptr_q + 1'b1;
    assign next_adr   = fifo_mem[next_ptr][65:36];
    // Continue only inside the current 8-word line.
    assign burst_cont = (level_q >= (DEPTH_LOG + 1)'(2)) &&
                        (next_adr == head_adr + 30'd1) &&
                        (head_adr[2:0] != 3'b111);
`else
    assign burst_cont = 1'b0;
`endif

    // FIFO storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge wb_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {s_adr_i[31:2], s_sel_i, s_dat_i};
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // State register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: posted writes always drain before a read is issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    state_d = StWr;
                end else if (s_cyc_i && s_stb_i && !s_we_i && !s_ack_o) begin
                    state_d = StRd;
                end
            end
            StWr: begin
                if (m_ack_i) begin
                    state_d = burst_cont ? StWr : StGap;
                end
            end
            StGap: state_d = StIdle;
            StRd: begin
                if (m_ack_i) begin
                    state_d = StGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Downstream outputs; everything is zero whenever m_cyc_o is low.
    always_comb begin
        m_adr_o = '0;
        m_dat_o = '0;
        m_sel_o = '0;
        m_we_o  = 1'b0;
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_cti_o = 3'b000;
        m_bte_o = 2'b00;
        unique case (state_q)
            StWr: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = {head_adr, 2'b00};
                m_sel_o = head_sel;
                m_dat_o = head_dat;
`ifdef DDR2_WBUF_DRAIN_BURST_EN
                m_cti_o = burst_cont ? 3'b010 : 3'b111;
`else
                m_cti_o = 3'b000;
`endif
            end
            StRd: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_adr_o = {rd_adr_q, 2'b00};
                m_sel_o = rd_sel_q;
            end
            default: ;
        endcase
    end

    assign s_ack_d = push | rd_ack;

    // The read address is held so an upstream abort cannot disturb the access.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rd_adr_q <= '0;
            rd_sel_q <= '0;
            s_dat_q  <= '0;
            s_ack_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && state_d == StRd) begin
                rd_adr_q <= s_adr_i[31:2];
                rd_sel_q <= s_sel_i;
            end
            if (rd_done) begin
                s_dat_q <= m_dat_i;
            end
            s_ack_q <= s_ack_d;
        end
    end

    assign s_dat_o = s_dat_q;
    assign s_ack_o = s_ack_q;
    assign s_err_o = 1'b0;
    assign s_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ddr2_wbuf.sv
// Scoreboard bench for wb_ddr2_wbuf: expected downstream beats are queued as
// upstream stimulus is driven and popped when the arbiter-side model acks.
module tb_wb_ddr2_wbuf;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned DEPTH_LOG = 3;

    logic                 wb_clk = 1'b0;
    logic                 wb_rst_n = 1'b0;
    logic [31:0]          s_adr_i = '0, s_dat_i = '0;
    logic [3:0]           s_sel_i = '0;
    logic                 s_we_i = 1'b0, s_cyc_i = 1'b0, s_stb_i = 1'b0;
    logic [2:0]           s_cti_i = '0;
    logic [1:0]           s_bte_i = '0;
    logic [31:0]          s_dat_o;
    logic                 s_ack_o, s_err_o, s_rty_o;
    logic [31:0]          m_adr_o, m_dat_o;
    logic [3:0]           m_sel_o;
    logic                 m_we_o, m_cyc_o, m_stb_o;
    logic [2:0]           m_cti_o;
    logic [1:0]           m_bte_o;
    logic [31:0]          m_dat_i = '0;
    logic                 m_ack_i = 1'b0;
    logic [DEPTH_LOG:0]   wbuf_level;
    logic                 wbuf_full;

    wb_ddr2_wbuf #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .s_adr_i    (s_adr_i),
        .s_dat_i    (s_dat_i),
        .s_sel_i    (s_sel_i),
        .s_we_i     (s_we_i),
        .s_cyc_i    (s_cyc_i),
        .s_stb_i    (s_stb_i),
        .s_cti_i    (s_cti_i),
        .s_bte_i    (s_bte_i),
        .s_dat_o    (s_dat_o),
        .s_ack_o    (s_ack_o),
        .s_err_o    (s_err_o),
        .s_rty_o    (s_rty_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_sel_o    (m_sel_o),
        .m_we_o     (m_we_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_cti_o    (m_cti_o),
        .m_bte_o    (m_bte_o),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i),
        .wbuf_level (wbuf_level),
        .wbuf_full  (wbuf_full)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] model [logic [31:0]];
    logic [31:0] ram   [logic [31:0]];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc_cnt = 0;
    int          last_rd_ack_cyc = -10;
    int          last_wr_lat = 0;
    int          ack_delay = 5;
    logic        resp_en = 1'b0;
    logic        chk_next = 1'b0;
    logic        exp_cyc_next = 1'b0;

    always #5 wb_clk = ~wb_clk;

    initial begin
        forever begin
            @(posedge wb_clk);
            cyc_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_cti(input txn_t cur);
`ifdef DDR2_WBUF_DRAIN_BURST_EN
        if (!cur.we) return 3'b000;
        if (exp_q.size() > 0 && exp_q[0].we && exp_q[0].adr == cur.adr + 32'd4 &&
            cur.adr[4:2] != 3'b111) return 3'b010;
        return 3'b111;
`else
        return 3'b000;
`endif
    endfunction

    // Arbiter-side model: acks after ack_delay cycles of a held strobe.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge wb_clk);
            #1;
            m_ack_i = 1'b0;
            if (resp_en && wb_rst_n && m_cyc_o && m_stb_o) begin
                if (wait_cnt + 1 >= ack_delay) begin
                    m_ack_i  = 1'b1;
                    wait_cnt = 0;
                    if (m_we_o) ram[m_adr_o] = m_dat_o;
                    else m_dat_i = ram.exists(m_adr_o) ? ram[m_adr_o] : 32'h0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Downstream monitor: every acked beat is popped against the scoreboard.
    initial begin
        txn_t        e;
        logic [2:0]  cti;
        forever begin
            @(negedge wb_clk);
            if (chk_next) begin
                check_val("m_cyc_after_beat", m_cyc_o, exp_cyc_next);
                chk_next = 1'b0;
            end
            if (wb_rst_n && m_cyc_o && m_stb_o && m_ack_i) begin
                check_val("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e   = exp_q.pop_front();
                    cti = exp_cti(e);
                    check_val("m_adr", m_adr_o, e.adr);
                    check_val("m_we", m_we_o, e.we);
                    check_val("m_sel", m_sel_o, e.sel);
                    check_val("m_cti", m_cti_o, cti);
                    check_val("m_bte", m_bte_o, 2'b00);
                    if (e.we) check_val("m_dat", m_dat_o, e.dat);
                    else last_rd_ack_cyc = cyc_cnt;
                    chk_next     = 1'b1;
                    exp_cyc_next = (cti == 3'b010);
                end
            end
        end
    end

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        txn_t t;
        logic got;
        t = '{adr: adr, dat: dat, sel: 4'hF, we: 1'b1};
        exp_q.push_back(t);
        model[adr] = dat;
        s_adr_i = adr; s_dat_i = dat; s_sel_i = 4'hF; s_cti_i = 3'b000;
        s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge wb_clk);
            #1;
            if (s_ack_o) begin
                got = 1'b1;
                last_wr_lat = i;
                break;
            end
        end
        check_val("wr_ack", got, 1);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr);
        txn_t t;
        logic got;
        t = '{adr: adr, dat: 32'h0, sel: 4'hF, we: 1'b0};
        exp_q.push_back(t);
        s_adr_i = adr; s_sel_i = 4'hF; s_cti_i = 3'b000;
        s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge wb_clk);
            #1;
            if (s_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        check_val("rd_ack", got, 1);
        if (got) begin
            check_val("rd_dat", s_dat_o, model.exists(adr) ? model[adr] : 32'h0);
            check_val("rd_ack_latency", cyc_cnt, last_rd_ack_cyc + 1);
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge wb_clk);
            #1;
            if (wbuf_level == 0 && !m_cyc_o && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check_val("drain_done", done, 1);
    endtask

    initial begin
        logic early, got;
        txn_t t;
        logic [31:0] d9;

        // Reset values
        repeat (2) @(posedge wb_clk);
        #1;
        check_val("rst_outputs", {s_dat_o, s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o},
                  '0);
        check_val("rst_level", wbuf_level, 0);
        wb_rst_n = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1;
        check_val("idle_no_cyc", m_cyc_o, 0);

        // Single posted write
        resp_en = 1'b1; ack_delay = 5;
        wb_write(32'h100, 32'hDEADBEEF);
        check_val("wr_ack_lat", last_wr_lat, 0);
        wait_drain();
        check_val("ram_100", ram[32'h100], 32'hDEADBEEF);

        // Full FIFO: eight accepted, ninth held until a pop frees a slot
        resp_en = 1'b0;
        for (int i = 0; i < 8; i++) wb_write(32'h1000 + i * 8, $urandom);
        check_val("full_level", wbuf_level, 8);
        check_val("full_flag", wbuf_full, 1);
        d9 = $urandom;
        t = '{adr: 32'h1040, dat: d9, sel: 4'hF, we: 1'b1};
        exp_q.push_back(t);
        model[32'h1040] = d9;
        s_adr_i = 32'h1040; s_dat_i = d9; s_sel_i = 4'hF;
        s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        early = 1'b0;
        @(posedge wb_clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk);
            #1;
            if (s_ack_o) early = 1'b1;
        end
        check_val("full_hold", early, 0);
        ack_delay = 1; resp_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk);
            #1;
            if (s_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        check_val("ninth_ack", got, 1);
        check_val("ninth_level", wbuf_level, 8);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        wait_drain();

        // Read ordering behind posted writes
        resp_en = 1'b0;
        wb_write(32'h200, 32'h11112222);
        wb_write(32'h204, 32'h33334444);
        ack_delay = 4; resp_en = 1'b1;
        wb_read(32'h204);
        wait_drain();

        // Aborted read, then a normal read
        ack_delay = 5;
        t = '{adr: 32'h200, dat: 32'h0, sel: 4'hF, we: 1'b0};
        exp_q.push_back(t);
        s_adr_i = 32'h200; s_sel_i = 4'hF; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge wb_clk);
            #1;
            if (m_cyc_o && !m_we_o) begin
                got = 1'b1;
                break;
            end
        end
        check_val("abort_rd_started", got, 1);
        @(posedge wb_clk);
        #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge wb_clk);
            #1;
            if (s_ack_o) early = 1'b1;
        end
        check_val("abort_no_ack", early, 0);
        check_val("abort_idle", m_cyc_o, 0);
        wb_read(32'h200);
        wait_drain();

        // Line-bounded drain bursts (classic drains when the option is off)
        resp_en = 1'b0;
        wb_write(32'h3F0, 32'hA0A0A0A0);
        wb_write(32'h3F4, 32'hA1A1A1A1);
        wb_write(32'h3F8, 32'hA2A2A2A2);
        wb_write(32'h3FC, 32'hA3A3A3A3);
        wb_write(32'h400, 32'hA4A4A4A4);
        check_val("burst_level", wbuf_level, 5);
        ack_delay = 3; resp_en = 1'b1;
        wait_drain();
        wb_read(32'h3FC);

        // Asynchronous reset mid-cycle discards posted writes
        resp_en = 1'b0;
        wb_write(32'h800, 32'h55550000);
        wb_write(32'h808, 32'h55551111);
        check_val("pre_rst_level", wbuf_level, 2);
        @(posedge wb_clk);
        #3;
        wb_rst_n = 1'b0;
        #1;
        check_val("async_rst_level", wbuf_level, 0);
        check_val("async_rst_outs", {s_dat_o, s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o}, '0);
        exp_q.delete();
        chk_next = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
        resp_en = 1'b1;
        repeat (4) @(posedge wb_clk);
        #1;
        check_val("post_rst_no_cyc", m_cyc_o, 0);
        check_val("post_rst_level", wbuf_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
